// File: rtl/pcb_read_responder.sv
`default_nettype none
// ============================================================================
// Module      : pcb_read_responder
// Description : Packet-buffer-side responder for host transmit reads. Serves
//               one outstanding single-line read from the packet RAM, forwards
//               bufid free requests to the free-list manager, and advertises
//               read credit from the downstream data FIFO fill level.
//               Optional statistics counters: define PCB_READ_RESP_STAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pcb_read_responder #(
    parameter int RAM_RD_LATENCY = 2,   // 1..4
    parameter int FIFO_AF_TH     = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [15:0]  iv_pkt_raddr,
    input  logic         i_pkt_rd,
    output logic         o_pkt_raddr_ack,
    output logic         o_pkt_rd_req,
    input  logic [4:0]   iv_fifo_usedw,
    output logic [15:0]  ov_ram_raddr,
    output logic         o_ram_rd,
    input  logic [133:0] iv_ram_rdata,
    output logic [133:0] ov_pkt_data,
    output logic         o_pkt_rx_valid,
    output logic         o_pkt_last_cycle_rx,
    input  logic [8:0]   iv_pkt_bufid,
    input  logic         i_pkt_bufid_wr,
    output logic         o_pkt_bufid_ack,
    output logic [8:0]   ov_free_bufid,
    output logic         o_free_bufid_wr,
    output logic [1:0]   ov_rd_state,
    output logic [31:0]  ov_rd_cnt,
    output logic [31:0]  ov_free_cnt
);

    localparam logic [2:0] c_LAT   = 3'(RAM_RD_LATENCY);
    localparam logic [5:0] c_AF_TH = 6'(FIFO_AF_TH);

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_ISSUE = 2'd1,
        RD_WAIT  = 2'd2,
        RD_GAP   = 2'd3
    } rd_state_t;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_ACK  = 2'd1,
        F_GAP  = 2'd2
    } f_state_t;

    rd_state_t      r_rd_state_q, w_rd_state_d;
    logic [15:0]    r_raddr_q,    w_raddr_d;
    logic           r_ram_rd_q,   w_ram_rd_d;
    logic [2:0]     r_cnt_q,      w_cnt_d;
    logic [133:0]   r_data_q,     w_data_d;
    logic           r_valid_q,    w_valid_d;
    logic           r_last_q,     w_last_d;
    logic           r_rd_req_q;

    f_state_t       r_f_state_q,  w_f_state_d;
    logic [8:0]     r_fbufid_q,   w_fbufid_d;
    logic           r_fwr_q,      w_fwr_d;

    // Read FSM next state: the ack/strobe are registered on the accepting
    // edge so they are visible for exactly the RD_ISSUE cycle.
    always_comb begin
        w_rd_state_d = r_rd_state_q;
        w_raddr_d    = r_raddr_q;
        w_ram_rd_d   = 1'b0;
        w_cnt_d      = r_cnt_q;
        w_data_d     = r_data_q;
        w_valid_d    = 1'b0;
        w_last_d     = 1'b0;
        case (r_rd_state_q)
            RD_IDLE: begin
                if (i_pkt_rd) begin
                    w_raddr_d    = iv_pkt_raddr;
                    w_ram_rd_d   = 1'b1;
                    w_rd_state_d = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                w_cnt_d      = c_LAT;
                w_rd_state_d = RD_WAIT;
            end
            RD_WAIT: begin
                w_cnt_d = r_cnt_q - 3'd1;
                if (r_cnt_q == 3'd1) begin
                    w_data_d     = iv_ram_rdata;
                    w_valid_d    = 1'b1;
                    w_last_d     = iv_ram_rdata[133];
                    w_rd_state_d = RD_GAP;
                end
            end
            default: begin
                // RD_GAP: requester is still dropping its level, ignore it
                w_rd_state_d = RD_IDLE;
            end
        endcase
    end

    // Free FSM next state: one accept per three cycles at most.
    always_comb begin
        w_f_state_d = r_f_state_q;
        w_fbufid_d  = r_fbufid_q;
        w_fwr_d     = 1'b0;
        case (r_f_state_q)
            F_IDLE: begin
                if (i_pkt_bufid_wr) begin
                    w_fbufid_d  = iv_pkt_bufid;
                    w_fwr_d     = 1'b1;
                    w_f_state_d = F_ACK;
                end
            end
            F_ACK:   w_f_state_d = F_GAP;
            default: w_f_state_d = F_IDLE;
        endcase
    end

    // State and output registers for both paths plus the credit flag.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_state_q <= RD_IDLE;
            r_raddr_q    <= '0;
            r_ram_rd_q   <= 1'b0;
            r_cnt_q      <= '0;
            r_data_q     <= '0;
            r_valid_q    <= 1'b0;
            r_last_q     <= 1'b0;
            r_rd_req_q   <= 1'b0;
            r_f_state_q  <= F_IDLE;
            r_fbufid_q   <= '0;
            r_fwr_q      <= 1'b0;
        end else begin
            r_rd_state_q <= w_rd_state_d;
            r_raddr_q    <= w_raddr_d;
            r_ram_rd_q   <= w_ram_rd_d;
            r_cnt_q      <= w_cnt_d;
            r_data_q     <= w_data_d;
            r_valid_q    <= w_valid_d;
            r_last_q     <= w_last_d;
            r_rd_req_q   <= ({1'b0, iv_fifo_usedw} < c_AF_TH);
            r_f_state_q  <= w_f_state_d;
            r_fbufid_q   <= w_fbufid_d;
            r_fwr_q      <= w_fwr_d;
        end
    end

    assign o_pkt_raddr_ack     = r_ram_rd_q;
    assign o_ram_rd            = r_ram_rd_q;
    assign ov_ram_raddr        = r_raddr_q;
    assign ov_pkt_data         = r_data_q;
    assign o_pkt_rx_valid      = r_valid_q;
    assign o_pkt_last_cycle_rx = r_last_q;
    assign o_pkt_rd_req        = r_rd_req_q;
    assign o_pkt_bufid_ack     = r_fwr_q;
    assign o_free_bufid_wr     = r_fwr_q;
    assign ov_free_bufid       = r_fbufid_q;
    assign ov_rd_state         = r_rd_state_q;

`ifdef PCB_READ_RESP_STAT_EN
    logic [31:0] r_rd_cnt_q;
    logic [31:0] r_free_cnt_q;

    // Counters step on the same edge that raises valid / free push, so the
    // count is visible together with the pulse it counts.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_cnt_q   <= '0;
            r_free_cnt_q <= '0;
        end else begin
            if (w_valid_d) r_rd_cnt_q   <= r_rd_cnt_q + 32'd1;
            if (w_fwr_d)   r_free_cnt_q <= r_free_cnt_q + 32'd1;
        end
    end

    assign ov_rd_cnt   = r_rd_cnt_q;
    assign ov_free_cnt = r_free_cnt_q;
`else
    assign ov_rd_cnt   = 32'd0;
    assign ov_free_cnt = 32'd0;
`endif

endmodule
`default_nettype wire
